// File: rtl/memory_pkg.sv
// Shared types and memory-op helpers for the MIPS memory stage.
// Alignment exceptions are enabled by defining MEM_ADDR_EXC_EN (see memory_stage).
package memory_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [4:0]  writereg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pcplus4;
    logic        in_delay_slot;
    logic        exc_if_adel;
    logic        exc_ri;
    logic        exc_ov;
    logic        exc_sys;
    logic        exc_bp;
  } execute_data_t;

  typedef struct packed {
    execute_data_t ex;
    logic [31:0]   result;
    logic          exc_adel;
    logic          exc_ades;
    logic [31:0]   badvaddr;
  } memory_data_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} mem_state_t;

  typedef enum logic [3:0] {
    MOP_NONE, MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_SB, MOP_SH, MOP_SW
  } mem_op_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [5:0] OPC_LB  = 6'h20;
  localparam logic [5:0] OPC_LH  = 6'h21;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_LBU = 6'h24;
  localparam logic [5:0] OPC_LHU = 6'h25;
  localparam logic [5:0] OPC_SB  = 6'h28;
  localparam logic [5:0] OPC_SH  = 6'h29;
  localparam logic [5:0] OPC_SW  = 6'h2B;

  function automatic mem_op_t decode_mem_op(input logic [31:0] instr);
    mem_op_t op;
    case (instr[31:26])
      OPC_LB:  op = MOP_LB;
      OPC_LBU: op = MOP_LBU;
      OPC_LH:  op = MOP_LH;
      OPC_LHU: op = MOP_LHU;
      OPC_LW:  op = MOP_LW;
      OPC_SB:  op = MOP_SB;
      OPC_SH:  op = MOP_SH;
      OPC_SW:  op = MOP_SW;
      default: op = MOP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_load_op(input mem_op_t op);
    return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
           (op == MOP_LHU) || (op == MOP_LW);
  endfunction

  function automatic logic is_store_op(input mem_op_t op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  function automatic logic [1:0] op_size(input mem_op_t op);
    logic [1:0] sz;
    case (op)
      MOP_LH, MOP_LHU, MOP_SH: sz = SIZE_HALF;
      MOP_LW, MOP_SW:          sz = SIZE_WORD;
      default:                 sz = SIZE_BYTE;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input mem_op_t op, input logic [1:0] a);
    logic [1:0] sz;
    sz = op_size(op);
    return ((sz == SIZE_HALF) && a[0]) || ((sz == SIZE_WORD) && (a != 2'b00));
  endfunction

  // Without alignment exceptions, half/word accesses silently round down.
  function automatic logic [31:0] align_addr(input mem_op_t op, input logic [31:0] a);
    logic [31:0] r;
    r = a;
    case (op_size(op))
      SIZE_HALF: r[0]   = 1'b0;
      SIZE_WORD: r[1:0] = 2'b00;
      default:   ;
    endcase
    return r;
  endfunction

  function automatic logic has_upstream_exc(input execute_data_t d);
    return d.exc_if_adel | d.exc_ri | d.exc_ov | d.exc_sys | d.exc_bp;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobe/data replication and load
// lane selection with sign/zero extension.
module mem_align
  import memory_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_raw_i,
  output logic [3:0]  strobe_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = load_raw_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = load_raw_i[15:8];
      2'd2:    byte_sel = load_raw_i[23:16];
      2'd3:    byte_sel = load_raw_i[31:24];
      default: byte_sel = load_raw_i[7:0];
    endcase
  end

  assign half_sel = addr_lo_i[1] ? load_raw_i[31:16] : load_raw_i[15:0];

  always_comb begin
    strobe_o     = 4'b0000;
    store_data_o = 32'h0;
    load_data_o  = load_raw_i;
    case (op_i)
      MOP_SB: begin
        strobe_o     = 4'b0001 << addr_lo_i;
        store_data_o = {4{store_data_i[7:0]}};
      end
      MOP_SH: begin
        strobe_o     = 4'b0011 << addr_lo_i;
        store_data_o = {2{store_data_i[15:0]}};
      end
      MOP_SW: begin
        strobe_o     = 4'b1111;
        store_data_o = store_data_i;
      end
      MOP_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      MOP_LBU: load_data_o = {24'h0, byte_sel};
      MOP_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
      MOP_LHU: load_data_o = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: one bus request per load/store, load alignment, writeback handoff.
// Define MEM_ADDR_EXC_EN to raise AdEL/AdES on misaligned half/word accesses.
module memory_stage
  import memory_pkg::*;
#(
  parameter int KSEG_MAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  execute_data_t in_data,
  output logic          dreq_valid,
  output logic [31:0]   dreq_addr,
  output logic [1:0]    dreq_size,
  output logic [3:0]    dreq_strobe,
  output logic [31:0]   dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [31:0]   dresp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output memory_data_t  out_data
);

  mem_state_t    state_q, state_d;
  execute_data_t ex_q, ex_d;
  memory_data_t  out_q, out_d;

  mem_op_t      in_op, op_q;
  logic         accept;
  logic         in_misalign, in_adel, in_ades, in_upexc, in_bus;
  logic [31:0]  eaddr, paddr;
  logic [3:0]   strobe;
  logic [31:0]  store_data, load_data;
  memory_data_t mem_out, pass_out;

  assign in_op    = decode_mem_op(in_data.instr);
  assign op_q     = decode_mem_op(ex_q.instr);
  assign in_upexc = has_upstream_exc(in_data);

`ifdef MEM_ADDR_EXC_EN
  assign in_misalign = (in_op != MOP_NONE) && misaligned(in_op, in_data.aluout[1:0]);
  assign eaddr       = ex_q.aluout;
`else
  assign in_misalign = 1'b0;
  assign eaddr       = align_addr(op_q, ex_q.aluout);
`endif

  // An upstream exception outranks our own address check.
  assign in_adel = in_misalign && !in_upexc && is_load_op(in_op);
  assign in_ades = in_misalign && !in_upexc && is_store_op(in_op);
  assign in_bus  = (in_op != MOP_NONE) && !in_upexc && !in_misalign;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) map onto physical 0x0000_0000 upward.
  assign paddr = ((KSEG_MAP != 0) && (eaddr[31:30] == 2'b10)) ? {3'b000, eaddr[28:0]} : eaddr;

  mem_align u_align (
    .op_i         (op_q),
    .addr_lo_i    (eaddr[1:0]),
    .store_data_i (ex_q.writedata),
    .load_raw_i   (dresp_data),
    .strobe_o     (strobe),
    .store_data_o (store_data),
    .load_data_o  (load_data)
  );

  always_comb begin
    mem_out        = '0;
    mem_out.ex     = ex_q;
    mem_out.result = is_load_op(op_q) ? load_data : ex_q.aluout;
  end

  always_comb begin
    pass_out          = '0;
    pass_out.ex       = in_data;
    pass_out.result   = in_data.aluout;
    pass_out.exc_adel = in_adel;
    pass_out.exc_ades = in_ades;
    pass_out.badvaddr = (in_adel || in_ades) ? in_data.aluout : 32'h0;
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  // The instruction offered alongside a flush is younger and dies with it.
  assign accept   = in_valid && in_ready && !flush;

  assign dreq_valid  = (state_q == REQ);
  assign dreq_addr   = paddr;
  assign dreq_size   = op_size(op_q);
  assign dreq_strobe = dreq_valid ? strobe : 4'b0000;
  assign dreq_data   = store_data;

  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    out_d   = out_q;
    if (flush) begin
      // Once addr_ok is seen the bus owes us a response that must be swallowed.
      case (state_q)
        WAIT, DRAIN: state_d = dresp_data_ok ? IDLE : DRAIN;
        default:     state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              state_d = DONE;
              out_d   = mem_out;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            state_d = DONE;
            out_d   = mem_out;
          end
        end
        DONE:    if (out_ready) state_d = IDLE;
        DRAIN:   if (dresp_data_ok) state_d = IDLE;
        default: ;
      endcase
      if (accept) begin
        ex_d = in_data;
        if (in_bus) begin
          state_d = REQ;
        end else begin
          state_d = DONE;
          out_d   = pass_out;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ex_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of single transactions plus
// hand-written multi-cycle sequences (stalls, flush, back-pressure, reset).
module tb_memory_stage;
  import memory_pkg::*;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  execute_data_t in_data;
  logic          dreq_valid;
  logic [31:0]   dreq_addr;
  logic [1:0]    dreq_size;
  logic [3:0]    dreq_strobe;
  logic [31:0]   dreq_data;
  logic          dresp_addr_ok, dresp_data_ok;
  logic [31:0]   dresp_data;
  logic          out_valid, out_ready;
  memory_data_t  out_data;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    string       name;
    logic [5:0]  opc;
    logic [5:0]  funct;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          upExc;
    bit          isMem;
    bit          isStore;
    logic [31:0] expAddr;
    logic [1:0]  expSize;
    logic [3:0]  expStrobe;
    logic [31:0] expData;
    logic [31:0] expResult;
  } vec_t;

  vec_t vecs[$];

  memory_stage #(.KSEG_MAP(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic execute_data_t mkIn(input logic [5:0] opc, input logic [5:0] fn,
                                         input logic [31:0] alu, input logic [31:0] wd,
                                         input bit upExc);
    execute_data_t d;
    d           = '0;
    d.instr     = {opc, 20'h0, fn};
    d.aluout    = alu;
    d.writedata = wd;
    d.writereg  = 5'd3;
    d.pcplus4   = 32'h0040_0004;
    d.exc_ri    = upExc;
    return d;
  endfunction

  function automatic void addVec(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [31:0] rd, input bit upExc, input bit isMem,
                                 input bit isStore, input logic [31:0] eAddr,
                                 input logic [1:0] eSize, input logic [3:0] eStrobe,
                                 input logic [31:0] eData, input logic [31:0] eResult);
    vec_t v;
    v.name = nm; v.opc = opc; v.funct = fn; v.alu = alu; v.wdata = wd; v.rdata = rd;
    v.upExc = upExc; v.isMem = isMem; v.isStore = isStore; v.expAddr = eAddr;
    v.expSize = eSize; v.expStrobe = eStrobe; v.expData = eData; v.expResult = eResult;
    vecs.push_back(v);
  endfunction

  // One complete transaction from a table entry; the bus answers addr_ok and data_ok together.
  task automatic applyStimulus(input vec_t v);
    in_data  = mkIn(v.opc, v.funct, v.alu, v.wdata, v.upExc);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (v.isMem) begin
      checkOutput({v.name, " dreq_valid"}, {31'b0, dreq_valid}, 32'd1);
      checkOutput({v.name, " addr"}, dreq_addr, v.expAddr);
      checkOutput({v.name, " size"}, {30'b0, dreq_size}, {30'b0, v.expSize});
      checkOutput({v.name, " strobe"}, {28'b0, dreq_strobe}, {28'b0, v.expStrobe});
      if (v.isStore) checkOutput({v.name, " wdata"}, dreq_data, v.expData);
      dresp_addr_ok = 1'b1;
      dresp_data_ok = 1'b1;
      dresp_data    = v.rdata;
      step();
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
    end
    checkOutput({v.name, " no dreq in DONE"}, {31'b0, dreq_valid}, 32'd0);
    checkOutput({v.name, " out_valid"}, {31'b0, out_valid}, 32'd1);
    if (!v.isStore) checkOutput({v.name, " result"}, out_data.result, v.expResult);
    checkOutput({v.name, " writereg"}, {27'b0, out_data.ex.writereg}, 32'd3);
    if (v.upExc) checkOutput({v.name, " exc_ri pass"}, {31'b0, out_data.ex.exc_ri}, 32'd1);
    step();
    checkOutput({v.name, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b1;

    addVec("SW kseg0", OPC_SW, 6'h0, 32'h8000_0010, 32'h1234_5678, 32'h0, 0, 1, 1,
           32'h0000_0010, SIZE_WORD, 4'hF, 32'h1234_5678, 32'h0);
    addVec("LB", OPC_LB, 6'h0, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 1, 0,
           32'h0000_1003, SIZE_BYTE, 4'h0, 32'h0, 32'hFFFF_FF80);
    addVec("LBU", OPC_LBU, 6'h0, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 1, 0,
           32'h0000_1003, SIZE_BYTE, 4'h0, 32'h0, 32'h0000_0080);
    addVec("LH kseg1", OPC_LH, 6'h0, 32'hA000_0022, 32'h0, 32'h8001_7FFF, 0, 1, 0,
           32'h0000_0022, SIZE_HALF, 4'h0, 32'h0, 32'hFFFF_8001);
    addVec("LHU", OPC_LHU, 6'h0, 32'h0000_0040, 32'h0, 32'h8001_9ABC, 0, 1, 0,
           32'h0000_0040, SIZE_HALF, 4'h0, 32'h0, 32'h0000_9ABC);
    addVec("LW", OPC_LW, 6'h0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 1, 0,
           32'h0000_0104, SIZE_WORD, 4'h0, 32'h0, 32'hDEAD_BEEF);
    addVec("SB", OPC_SB, 6'h0, 32'h0000_0201, 32'h0000_00AB, 32'h0, 0, 1, 1,
           32'h0000_0201, SIZE_BYTE, 4'h2, 32'hABAB_ABAB, 32'h0);
    addVec("SH", OPC_SH, 6'h0, 32'h0000_0302, 32'h0000_CAFE, 32'h0, 0, 1, 1,
           32'h0000_0302, SIZE_HALF, 4'hC, 32'hCAFE_CAFE, 32'h0);
    addVec("LB lane2", OPC_LB, 6'h0, 32'h0000_0002, 32'h0, 32'h1122_3344, 0, 1, 0,
           32'h0000_0002, SIZE_BYTE, 4'h0, 32'h0, 32'h0000_0022);
    addVec("LW kuseg", OPC_LW, 6'h0, 32'h7FFF_FFF0, 32'h0, 32'h0102_0304, 0, 1, 0,
           32'h7FFF_FFF0, SIZE_WORD, 4'h0, 32'h0, 32'h0102_0304);
    addVec("LW kseg2", OPC_LW, 6'h0, 32'hC000_0000, 32'h0, 32'hA5A5_A5A5, 0, 1, 0,
           32'hC000_0000, SIZE_WORD, 4'h0, 32'h0, 32'hA5A5_A5A5);
    addVec("LW kseg1 top", OPC_LW, 6'h0, 32'hBFC0_0100, 32'h0, 32'h0F0F_0F0F, 0, 1, 0,
           32'h1FC0_0100, SIZE_WORD, 4'h0, 32'h0, 32'h0F0F_0F0F);
    addVec("ADDU", 6'h00, 6'h21, 32'h0000_0005, 32'h0, 32'h0, 0, 0, 0,
           32'h0, SIZE_BYTE, 4'h0, 32'h0, 32'h0000_0005);
    addVec("LW upstream exc", OPC_LW, 6'h0, 32'h0000_1000, 32'h0, 32'h0, 1, 0, 0,
           32'h0, SIZE_BYTE, 4'h0, 32'h0, 32'h0000_1000);

    step(); step();
    reset = 1'b0;
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset dreq_valid", {31'b0, dreq_valid}, 32'd0);
    checkOutput("reset dreq_strobe", {28'b0, dreq_strobe}, 32'd0);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset out_data zero", {31'b0, out_data == '0}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // LH with addr_ok after 3 REQ cycles and data_ok 2 cycles later.
    in_data = mkIn(OPC_LH, 6'h0, 32'h0000_0502, 32'h0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall dreq_valid", {31'b0, dreq_valid}, 32'd1);
      checkOutput("stall addr", dreq_addr, 32'h0000_0502);
      checkOutput("stall size", {30'b0, dreq_size}, {30'b0, SIZE_HALF});
      checkOutput("stall strobe", {28'b0, dreq_strobe}, 32'd0);
      if (c < 2) step();
    end
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    checkOutput("stall wait dreq off", {31'b0, dreq_valid}, 32'd0);
    checkOutput("stall wait no out", {31'b0, out_valid}, 32'd0);
    step();
    checkOutput("stall wait2 no out", {31'b0, out_valid}, 32'd0);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h8765_4321;
    step();
    dresp_data_ok = 1'b0;
    checkOutput("stall out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("stall result", out_data.result, 32'hFFFF_8765);
    step();

    // Flush while WAIT: response must be drained and never reach writeback.
    in_data = mkIn(OPC_LW, 6'h0, 32'h0000_0600, 32'h0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("drain in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("drain out_valid", {31'b0, out_valid}, 32'd0);
    step();
    checkOutput("drain2 in_ready", {31'b0, in_ready}, 32'd0);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h1357_9BDF;
    step();
    dresp_data_ok = 1'b0;
    checkOutput("drain done out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("drain done in_ready", {31'b0, in_ready}, 32'd1);

    // Flush in REQ retracts the request.
    in_data = mkIn(OPC_LW, 6'h0, 32'h0000_0610, 32'h0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("flushreq dreq before", {31'b0, dreq_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flushreq dreq after", {31'b0, dreq_valid}, 32'd0);
    checkOutput("flushreq out_valid", {31'b0, out_valid}, 32'd0);

    // Flush in DONE drops out_valid.
    in_data = mkIn(6'h00, 6'h21, 32'h0000_0009, 32'h0, 0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checkOutput("flushdone pre", {31'b0, out_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    checkOutput("flushdone out_valid", {31'b0, out_valid}, 32'd0);

    // ADDU then LW back-to-back with writeback stalled for 2 cycles.
    out_ready = 1'b0;
    in_data = mkIn(6'h00, 6'h21, 32'h0000_0077, 32'h0, 0);
    in_valid = 1'b1;
    step();
    in_data = mkIn(OPC_LW, 6'h0, 32'h0000_0700, 32'h0, 0);
    checkOutput("b2b out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("b2b in_ready low", {31'b0, in_ready}, 32'd0);
    checkOutput("b2b held result", out_data.result, 32'h0000_0077);
    step();
    checkOutput("b2b held result2", out_data.result, 32'h0000_0077);
    checkOutput("b2b held instr", out_data.ex.instr, 32'h0000_0021);
    out_ready = 1'b1;
    #1;
    checkOutput("b2b in_ready high", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("b2b lw dreq", {31'b0, dreq_valid}, 32'd1);
    checkOutput("b2b lw addr", dreq_addr, 32'h0000_0700);
    checkOutput("b2b lw no out", {31'b0, out_valid}, 32'd0);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h55AA_55AA;
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    checkOutput("b2b lw result", out_data.result, 32'h55AA_55AA);
    step();

`ifdef MEM_ADDR_EXC_EN
    in_data = mkIn(OPC_LW, 6'h0, 32'h0000_0802, 32'h0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("adel dreq_valid", {31'b0, dreq_valid}, 32'd0);
    checkOutput("adel out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("adel flag", {31'b0, out_data.exc_adel}, 32'd1);
    checkOutput("adel badvaddr", out_data.badvaddr, 32'h0000_0802);
    step();
    in_data = mkIn(OPC_SH, 6'h0, 32'h0000_0303, 32'h0000_BEEF, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("ades dreq_valid", {31'b0, dreq_valid}, 32'd0);
    checkOutput("ades flag", {31'b0, out_data.exc_ades}, 32'd1);
    checkOutput("ades badvaddr", out_data.badvaddr, 32'h0000_0303);
    step();
`else
    applyStimulus('{"LW misaligned", OPC_LW, 6'h0, 32'h0000_0802, 32'h0, 32'h1122_3344, 1'b0,
                    1'b1, 1'b0, 32'h0000_0800, SIZE_WORD, 4'h0, 32'h0, 32'h1122_3344});
    applyStimulus('{"SH misaligned", OPC_SH, 6'h0, 32'h0000_0303, 32'h0000_BEEF, 32'h0, 1'b0,
                    1'b1, 1'b1, 32'h0000_0302, SIZE_HALF, 4'hC, 32'hBEEF_BEEF, 32'h0});
    checkOutput("no adel default", {31'b0, out_data.exc_adel}, 32'd0);
`endif

    // Reset in the middle of a transaction returns to IDLE.
    in_data = mkIn(OPC_LW, 6'h0, 32'h0000_0900, 32'h0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("midreset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("midreset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset dreq_valid", {31'b0, dreq_valid}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
